id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register and operand-select stage; feeds ALU input1/input2/aluControl/shamt directly.
//  Holds one decoded instruction per cycle and resolves RAW hazards by EX/MEM + MEM/WB forwarding.
//  Detects load-use hazards, inserts a one-cycle bubble and stalls IF/ID. Flush from branch resolution kills ID.
// PARAMETERS
//  DATA_W   32  datapath width (ALU operand width)
//  REG_AW   5   register-number width; register 0 is hardwired zero
// PORTS
//  clk            in   1       rising-edge clock
//  reset          in   1       synchronous, active-high
//  flush          in   1       kill instruction entering EX this cycle (branch taken)
//  id_valid       in   1       ID holds a real instruction
//  id_readData1   in   DATA_W  register file rs value
//  id_readData2   in   DATA_W  register file rt value
//  id_signExtImm  in   DATA_W  sign-extended immediate
//  id_rs,id_rt,id_rd in REG_AW source/dest register numbers
//  id_aluControl  in   4       ALU op code (0010 add, 0110 sub, 0000 and, 0001 or)
//  id_shamt       in   5       shift amount, passed through
//  id_aluSrc,id_regDst,id_memRead,id_memWrite,id_regWrite,id_memToReg  in 1  decoded controls
//  mem_regWrite   in   1       EX/MEM stage writes a register
//  mem_writeReg   in   REG_AW  EX/MEM destination
//  mem_aluResult  in   DATA_W  EX/MEM ALU result
//  wb_regWrite    in   1       MEM/WB stage writes a register
//  wb_writeReg    in   REG_AW  MEM/WB destination
//  wb_writeData   in   DATA_W  MEM/WB write-back value
//  stall          out  1       hold PC and IF/ID this cycle
//  ex_valid       out  1       EX holds a real instruction
//  ex_input1,ex_input2 out DATA_W  ALU operands
//  ex_aluControl  out  4;  ex_shamt out 5;  ex_writeReg out REG_AW (rd if regDst else rt)
//  ex_memWriteData out DATA_W  forwarded rt for stores
//  ex_memRead,ex_memWrite,ex_regWrite,ex_memToReg  out 1  controls to EX/MEM
// BEHAVIOUR
//  - Reset: all registers 0; ex_valid=0, all controls 0, stall=0; ex_input1/2=0.
//  - Per edge, priority reset > flush > stall > load. Flush/stall load a bubble: ex_valid=0, all ex_* controls 0.
//  - Load: capture all id_* fields; ex_valid=id_valid. Latency ID->EX one cycle.
//  - Bubble/invalid entries never write: regWrite/memWrite/memRead forced 0 whenever ex_valid=0.
//  - stall (comb) = !flush & id_valid & ex_valid & ex_memRead & ex_writeReg!=0 & (ex_writeReg==id_rs | ex_writeReg==id_rt).
//    Asserts exactly one cycle per load-use pair (bubble clears ex_memRead next cycle).
//  - Forwarding (comb, on registered rs/rt): if mem_regWrite & mem_writeReg!=0 & match -> mem_aluResult;
//    else if wb_regWrite & wb_writeReg!=0 & match -> wb_writeData; else registered regfile value. MEM beats WB.
//  - ex_input1 = fwd(rs); ex_input2 = aluSrc ? signExtImm : fwd(rt); ex_memWriteData = fwd(rt).
//  - Register 0 never forwarded; reads of $0 yield registered regfile value (0).
//  - Register file is write-first; no WB->ID hazard handled here.
//  - Reset mid-stall: stall drops next cycle with ex_valid=0.
// CONFIGURATION
//  FORWARDING_EN defined: forwarding muxes as above.
//  Not defined: no muxes, mem_aluResult/wb_writeData ignored; stall additionally asserts on any RAW
//   (id_rs/id_rt, nonzero) against EX (ex_regWrite & ex_valid) or MEM (mem_regWrite) destination; same priority rules.
// STRUCTURE
//  Shared package mips_pkg: ALU control codes (ALU_AND/OR/ADD/SUB), REG_ZERO, fwd_sel_t {FWD_REG,FWD_MEM,FWD_WB}.
//  One sub-module forward_mux (selects per operand; instantiated for rs and rt); hazard logic inline.
// TESTING
//  1 reset high 2 cycles with id_valid=1 -> ex_valid=0, all controls 0, stall=0.
//  2 add $3 then sub using $3 next; mem_writeReg=3, mem_aluResult=0x10 -> ex_input1=0x10 (FORWARDING_EN).
//  3 mem and wb both write $5 (0xAA / 0xBB), EX reads $5 -> ex_input1=0xAA; writes to $0 -> no forward.
//  4 lw $2 in EX, ID reads $2 -> stall=1 one cycle, next ex_valid=0, then ex_input1=wb_writeData.
//  5 flush with load-use pending -> stall=0, bubble loaded, ex_regWrite=0.
//  6 FORWARDING_EN undefined: RAW on MEM dest $7 -> stall=1 until MEM retires $7.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU op codes, the hardwired-zero register
// number and the forwarding-source select type used by the operand muxes.
package mips_pkg;

  // ALU control codes as decoded in ID and consumed by the EX-stage ALU.
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  // Register $0 reads as zero and is never a forwarding target.
  localparam int unsigned REG_ZERO = 0;

  // Where an EX operand comes from.
  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

endpackage

// File: rtl/forward_mux.sv
// Per-operand forwarding mux for the EX stage.
// Build option: FORWARDING_EN selects the EX/MEM and MEM/WB bypass paths;
// without it the registered register-file value passes straight through.
module forward_mux
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              mem_regWrite,
  input  logic [REG_AW-1:0] mem_writeReg,
  input  logic [DATA_W-1:0] mem_aluResult,
  input  logic              wb_regWrite,
  input  logic [REG_AW-1:0] wb_writeReg,
  input  logic [DATA_W-1:0] wb_writeData,
  output logic [DATA_W-1:0] data
);

`ifdef FORWARDING_EN
  fwd_sel_t sel;

  // Pick the youngest producer of src; EX/MEM is younger than MEM/WB so it wins.
  always_comb begin
    sel = FWD_REG;
    if (mem_regWrite && (mem_writeReg != REG_AW'(REG_ZERO)) && (mem_writeReg == src)) begin
      sel = FWD_MEM;
    end else if (wb_regWrite && (wb_writeReg != REG_AW'(REG_ZERO)) && (wb_writeReg == src)) begin
      sel = FWD_WB;
    end
  end

  // Operand data according to the selected source.
  always_comb begin
    data = reg_data;
    unique case (sel)
      FWD_MEM: data = mem_aluResult;
      FWD_WB:  data = wb_writeData;
      default: data = reg_data;
    endcase
  end
`else
  // No bypass: hazards are resolved by stalling in the parent stage.
  assign data = reg_data;

  logic unused_fwd;
  assign unused_fwd = ^{src, mem_regWrite, mem_writeReg, mem_aluResult,
                        wb_regWrite, wb_writeReg, wb_writeData};
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand selection for the ALU.
// Holds one decoded instruction, resolves RAW hazards by forwarding from
// EX/MEM and MEM/WB, and stalls IF/ID on load-use hazards.
// Build option: FORWARDING_EN enables the bypass muxes; without it every RAW
// hazard against EX or MEM stalls instead.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_readData1,
  input  logic [DATA_W-1:0] id_readData2,
  input  logic [DATA_W-1:0] id_signExtImm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [3:0]        id_aluControl,
  input  logic [4:0]        id_shamt,
  input  logic              id_aluSrc,
  input  logic              id_regDst,
  input  logic              id_memRead,
  input  logic              id_memWrite,
  input  logic              id_regWrite,
  input  logic              id_memToReg,
  input  logic              mem_regWrite,
  input  logic [REG_AW-1:0] mem_writeReg,
  input  logic [DATA_W-1:0] mem_aluResult,
  input  logic              wb_regWrite,
  input  logic [REG_AW-1:0] wb_writeReg,
  input  logic [DATA_W-1:0] wb_writeData,
  output logic              stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_input1,
  output logic [DATA_W-1:0] ex_input2,
  output logic [3:0]        ex_aluControl,
  output logic [4:0]        ex_shamt,
  output logic [REG_AW-1:0] ex_writeReg,
  output logic [DATA_W-1:0] ex_memWriteData,
  output logic              ex_memRead,
  output logic              ex_memWrite,
  output logic              ex_regWrite,
  output logic              ex_memToReg
);

  logic              valid_q;
  logic [REG_AW-1:0] rs_q;
  logic [REG_AW-1:0] rt_q;
  logic [REG_AW-1:0] wreg_q;
  logic [DATA_W-1:0] rdata1_q;
  logic [DATA_W-1:0] rdata2_q;
  logic [DATA_W-1:0] imm_q;
  logic [3:0]        aluctl_q;
  logic [4:0]        shamt_q;
  logic              alusrc_q;
  logic              memread_q;
  logic              memwrite_q;
  logic              regwrite_q;
  logic              memtoreg_q;

  logic              bubble;
  logic [REG_AW-1:0] id_wreg;
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;
  logic              ex_hits_id;
  logic              load_use;
  logic              raw_stall;

  assign id_wreg = id_regDst ? id_rd : id_rt;
  assign bubble  = flush | stall;

  // Pipeline register: reset, then flush/stall bubble, then normal load.
  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      valid_q    <= 1'b0;
      rs_q       <= '0;
      rt_q       <= '0;
      wreg_q     <= '0;
      rdata1_q   <= '0;
      rdata2_q   <= '0;
      imm_q      <= '0;
      aluctl_q   <= '0;
      shamt_q    <= '0;
      alusrc_q   <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
    end else begin
      valid_q    <= id_valid;
      rs_q       <= id_rs;
      rt_q       <= id_rt;
      wreg_q     <= id_wreg;
      rdata1_q   <= id_readData1;
      rdata2_q   <= id_readData2;
      imm_q      <= id_signExtImm;
      aluctl_q   <= id_aluControl;
      shamt_q    <= id_shamt;
      alusrc_q   <= id_aluSrc;
      // An empty ID slot must never carry side-effecting controls into EX.
      memread_q  <= id_memRead  & id_valid;
      memwrite_q <= id_memWrite & id_valid;
      regwrite_q <= id_regWrite & id_valid;
      memtoreg_q <= id_memToReg & id_valid;
    end
  end

  forward_mux #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_fwd_rs (
    .src           (rs_q),
    .reg_data      (rdata1_q),
    .mem_regWrite  (mem_regWrite),
    .mem_writeReg  (mem_writeReg),
    .mem_aluResult (mem_aluResult),
    .wb_regWrite   (wb_regWrite),
    .wb_writeReg   (wb_writeReg),
    .wb_writeData  (wb_writeData),
    .data          (fwd_rs)
  );

  forward_mux #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_fwd_rt (
    .src           (rt_q),
    .reg_data      (rdata2_q),
    .mem_regWrite  (mem_regWrite),
    .mem_writeReg  (mem_writeReg),
    .mem_aluResult (mem_aluResult),
    .wb_regWrite   (wb_regWrite),
    .wb_writeReg   (wb_writeReg),
    .wb_writeData  (wb_writeData),
    .data          (fwd_rt)
  );

  // Load-use detection: a load in EX whose destination ID is about to read.
  always_comb begin
    ex_hits_id = (wreg_q != REG_AW'(REG_ZERO)) && ((wreg_q == id_rs) || (wreg_q == id_rt));
    load_use   = valid_q & memread_q & ex_hits_id;
  end

`ifdef FORWARDING_EN
  assign raw_stall = 1'b0;
`else
  logic ex_raw;
  logic mem_raw;

  // Without bypass, any pending producer in EX or MEM blocks the ID reader.
  always_comb begin
    ex_raw    = valid_q & regwrite_q & ex_hits_id;
    mem_raw   = mem_regWrite && (mem_writeReg != REG_AW'(REG_ZERO)) &&
                ((mem_writeReg == id_rs) || (mem_writeReg == id_rt));
    raw_stall = ex_raw | mem_raw;
  end
`endif

  // Flush kills the ID instruction anyway, so it overrides any stall request.
  always_comb begin
    stall = ~flush & id_valid & (load_use | raw_stall);
  end

  // EX-facing outputs; controls gated by valid so bubbles are inert.
  always_comb begin
    ex_valid        = valid_q;
    ex_input1       = fwd_rs;
    ex_input2       = alusrc_q ? imm_q : fwd_rt;
    ex_memWriteData = fwd_rt;
    ex_aluControl   = aluctl_q;
    ex_shamt        = shamt_q;
    ex_writeReg     = wreg_q;
    ex_memRead      = memread_q  & valid_q;
    ex_memWrite     = memwrite_q & valid_q;
    ex_regWrite     = regwrite_q & valid_q;
    ex_memToReg     = memtoreg_q & valid_q;
  end

endmodule
